mem_lsu: RTL and testbench

- Load/store unit between the pipeline memory stage and the word-wide data RAM.
- The data RAM is 32-bit, word-addressed by 11 bits, with combinational read and a single write enable.
- Converts byte-addressed byte/halfword/word requests into RAM accesses, using read-modify-write for sub-word stores.
- Performs lane extraction and sign/zero extension for loads, and flags misaligned accesses.

---
 rtl/mem_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the memory pipeline stage and a 32-bit
// word-addressed data RAM with combinational read. Sub-word stores use a
// read-modify-write sequence; loads get lane extraction and sign/zero
// extension; misaligned or illegal-size requests complete with resp_err.
// Optional build macro: LSU_ERRCNT_EN adds a saturating err_count output.
module mem_lsu #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef LSU_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_next;

  logic              accept;
  logic              req_bad;
  logic [ADDR_W+1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_we;
  logic              a_signed;
  logic [31:0]       a_wdata;
  logic [31:0]       rbuf;
  logic [31:0]       ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       merged;
  logic [31:0]       res_rdata;
  logic              res_err;

  assign accept = req_valid & req_ready;

  // Alignment / size legality of the incoming request.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                          state_next = RESP;
          else if (req_we && req_size == 2'b10) state_next = WR;
          else                                  state_next = RD;
        end
      end
      RD:      state_next = a_we ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register so reset drops them at once.
  always_comb begin
    req_ready  = (state == IDLE) && rst;
    ram_wen    = (state == WR);
    resp_valid = (state == RESP);
    ram_wdata  = (state == WR) ? merged : '0;
    ram_addr   = a_addr[ADDR_W+1:2];
    resp_rdata = res_rdata;
    resp_err   = res_err;
  end

  // Latch request fields on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_addr   <= '0;
      a_size   <= '0;
      a_we     <= 1'b0;
      a_signed <= 1'b0;
      a_wdata  <= '0;
    end else if (accept) begin
      a_addr   <= req_addr;
      a_size   <= req_size;
      a_we     <= req_we;
      a_signed <= req_signed;
      a_wdata  <= req_wdata;
    end
  end

  // Capture the RAM word read in RD for the read-modify-write merge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rbuf <= '0;
    else if (state == RD) rbuf <= ram_rdata;
  end

  // Load lane extraction and extension from the word being read this cycle.
  always_comb begin
    ld_byte = ram_rdata[{a_addr[1:0], 3'b000} +: 8];
    ld_half = ram_rdata[{a_addr[1], 4'b0000} +: 16];
    case (a_size)
      2'b00:   ld_data = {{24{a_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{a_signed & ld_half[15]}}, ld_half};
      default: ld_data = ram_rdata;
    endcase
  end

  // Store merge: replace the addressed lane(s) of the previously read word.
  always_comb begin
    merged = rbuf;
    case (a_size)
      2'b00:   merged[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
      2'b01:   merged[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
      default: merged = a_wdata;
    endcase
  end

  // Response data/error are loaded on the edge that enters RESP, using the
  // RAM word directly (identical to what rbuf captures), then held until
  // the next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_rdata <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && req_bad) begin
            res_rdata <= '0;
            res_err   <= 1'b1;
          end
        end
        RD: begin
          if (!a_we) begin
            res_rdata <= ld_data;
            res_err   <= 1'b0;
          end
        end
        WR: begin
          res_rdata <= '0;
          res_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_ERRCNT_EN
  // Saturating count of error responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_count <= '0;
    else if (state == RESP && res_err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a
// word-array reference model of the data RAM.
module tb_mem_lsu;

  localparam int AW = 11;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = '0;
  logic          req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] ram_addr;
  logic          ram_wen;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
`ifdef LSU_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  mem_lsu #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef LSU_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Data RAM: combinational read, clocked write; preload from the model.
  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];
  logic        init_req = 1'b1;

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < NW; i++) mem[i] <= ref_mem[i];
    end else if (ram_wen) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  int passed = 0;
  int total  = 0;
  int exp_errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request through the DUT, with expectations from the reference model.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [AW+1:0] addr, input logic [31:0] wdata);
    int          w, sh, lat, wens, exp_lat;
    logic        bad;
    logic [31:0] word, mask, v, exp_rd, new_word;
    logic [AW-1:0] waddr;
    logic [31:0] wdat;

    w    = int'(addr) / 4;
    sh   = (int'(addr) % 4) * 8;
    word = ref_mem[w];
    bad  = (size == 2'b11) || (size == 2'b01 && (int'(addr) % 2) != 0) ||
           (size == 2'b10 && (int'(addr) % 4) != 0);
    mask = (size == 2'b00) ? 32'h0000_00FF : (size == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    new_word = word;
    exp_rd   = 32'h0;
    if (bad) begin
      exp_lat = 1;
      if (exp_errs < 255) exp_errs++;
    end else if (we) begin
      exp_lat  = (size == 2'b10) ? 2 : 3;
      new_word = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[w] = new_word;
    end else begin
      exp_lat = 2;
      v = (word >> sh) & mask;
      if (sgn && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
      if (sgn && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    check({tag, "_ready"}, req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; wens = 0; waddr = '0; wdat = '0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (ram_wen) begin
        wens++;
        waddr = ram_addr;
        wdat  = ram_wdata;
      end
      if (resp_valid) break;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"}, resp_err, bad);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_wen_cycles"}, wens, (!bad && we) ? 1 : 0);
    if (!bad && we) begin
      check({tag, "_wen_addr"}, waddr, w);
      check({tag, "_wdata"}, wdat, new_word);
    end

    @(negedge clk);
    check({tag, "_pulse"}, resp_valid, 0);
    check({tag, "_hold"}, resp_rdata, exp_rd);
    check({tag, "_mem"}, mem[w], ref_mem[w]);
`ifdef LSU_ERRCNT_EN
    check({tag, "_errcnt"}, err_count, exp_errs);
`endif
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'h8899_AABB;

    // Reset state while rst held low; RAM preload happens on this edge.
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_ram_wen", ram_wen, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
`ifdef LSU_ERRCNT_EN
    check("rst_errcnt", err_count, 0);
`endif
    rst = 1'b1;
    #1 check("ready_after_rst", req_ready, 1);

    // Directed cases.
    do_req("ld_b_s_15",   1'b0, 2'b00, 1'b1, 13'h0015, 32'h0);
    do_req("ld_h_u_16",   1'b0, 2'b01, 1'b0, 13'h0016, 32'h0);
    do_req("ld_w_s_14",   1'b0, 2'b10, 1'b1, 13'h0014, 32'h0);
    do_req("st_b_17",     1'b1, 2'b00, 1'b0, 13'h0017, 32'h1234_565A);
    check("word5_after_st_b", mem[5], 32'h5A99_AABB);
    do_req("st_w_20",     1'b1, 2'b10, 1'b0, 13'h0020, 32'hDEAD_BEEF);
    do_req("err_ld_h_15", 1'b0, 2'b01, 1'b0, 13'h0015, 32'h0);
    do_req("err_st_w_22", 1'b1, 2'b10, 1'b0, 13'h0022, 32'hCAFE_F00D);
    do_req("err_size3",   1'b0, 2'b11, 1'b1, 13'h0010, 32'h0);
    do_req("ld_b_top",    1'b0, 2'b00, 1'b1, 13'h1FFF, 32'h0);
    do_req("st_w_top",    1'b1, 2'b10, 1'b0, 13'h1FFC, 32'h0BAD_F00D);
    do_req("ld_h_s_top",  1'b0, 2'b01, 1'b1, 13'h1FFE, 32'h0);
    do_req("st_h_02",     1'b1, 2'b01, 1'b0, 13'h0002, 32'hFFFF_8001);

    // Reset asserted during WR of a half store: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 13'h000C; req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_rd_wen", ram_wen, 0);
    @(negedge clk);
    check("rstwr_wr_wen", ram_wen, 1);
    rst = 1'b0;
    #1;
    check("rstwr_wen_drop", ram_wen, 0);
    check("rstwr_ready_low", req_ready, 0);
    check("rstwr_rdata_clr", resp_rdata, 0);
    repeat (2) begin
      @(negedge clk);
      check("rstwr_no_resp", resp_valid, 0);
    end
    check("rstwr_word3", mem[3], ref_mem[3]);
    exp_errs = 0;
`ifdef LSU_ERRCNT_EN
    check("rstwr_errcnt", err_count, 0);
`endif
    rst = 1'b1;
    #1 check("rstwr_ready_high", req_ready, 1);
    repeat (2) begin
      @(negedge clk);
      check("rstwr_still_no_resp", resp_valid, 0);
    end

    // Randomized requests over a small window plus the top of memory.
    for (int n = 0; n < 150; n++) begin
      logic [AW+1:0] a;
      if ($urandom_range(0, 7) == 0) a = 13'(NW * 4 - 1 - $urandom_range(0, 15));
      else                           a = 13'($urandom_range(0, 63));
      do_req("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
